// File: rtl/csr_access_unit.sv
// Zicsr initiator: sequences read / read-modify-write / write-back on the CSR file port.
// Optional access checking (read-only space, invalid funct3) is enabled by CSR_ACCESS_CHECK_EN.
module csr_access_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_num,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  rs1_zimm,
    input  logic [4:0]  rd_idx,
    input  logic [31:0] csr_readbus,
    output logic [31:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_we,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        rd_we,
    output logic        illegal,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t        state, state_nx;
    logic [CW-1:0] rd_cnt;
    logic [1:0]    op_q;
    logic [4:0]    rd_q;
    logic [4:0]    zimm_q;
    logic [31:0]   src_q;
    logic          read_q;
    logic          ill_q;
    logic [31:0]   wdata_nx;

    // Decode of the live request; only meaningful while IDLE samples start.
    logic        f3_valid;
    logic        op_rw;
    logic        req_writes;
    logic        req_illegal;
    logic [31:0] src_in;

    assign f3_valid   = (funct3[1:0] != 2'b00);
    assign op_rw      = (funct3[1:0] == 2'b01);
    assign src_in     = funct3[2] ? {27'b0, rs1_zimm} : rs1_data;
    assign req_writes = op_rw || (rs1_zimm != 5'd0);

`ifdef CSR_ACCESS_CHECK_EN
    assign req_illegal = !f3_valid || (req_writes && (csr_num[11:10] == 2'b11));
`else
    assign req_illegal = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!f3_valid || req_illegal)   state_nx = S_DONE;
                    else if (op_rw && rd_idx == 5'd0) state_nx = S_WRITE;
                    else                              state_nx = S_READ;
                end
            end
            S_READ:    if (rd_cnt == '0) state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = (op_q != 2'b01 && zimm_q == 5'd0) ? S_DONE : S_WRITE;
            S_WRITE:   state_nx = S_DONE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Write data enters WRITE either straight from IDLE (no read) or from CAPTURE.
    always_comb begin
        wdata_nx = src_q;
        if (state == S_IDLE) begin
            wdata_nx = src_in;
        end else begin
            case (op_q)
                2'b10:   wdata_nx = csr_readbus | src_q;
                2'b11:   wdata_nx = csr_readbus & ~src_q;
                default: wdata_nx = src_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state     <= S_IDLE;
            rd_cnt    <= '0;
            op_q      <= 2'b00;
            rd_q      <= 5'd0;
            zimm_q    <= 5'd0;
            src_q     <= 32'd0;
            read_q    <= 1'b0;
            ill_q     <= 1'b0;
            csr_addr  <= 32'd0;
            csr_wdata <= 32'd0;
            rd_data   <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                op_q     <= funct3[1:0];
                rd_q     <= rd_idx;
                zimm_q   <= rs1_zimm;
                src_q    <= src_in;
                csr_addr <= {18'b0, csr_num, 2'b00};
                read_q   <= (state_nx == S_READ);
                ill_q    <= req_illegal;
                rd_cnt   <= CW'(RD_LAT - 1);
            end else if (state == S_READ && rd_cnt != '0) begin
                rd_cnt <= rd_cnt - CW'(1);
            end
            if (state == S_CAPTURE) rd_data <= csr_readbus;
            if (state_nx == S_WRITE) csr_wdata <= wdata_nx;
        end
    end

    // start is sampled only in IDLE; done, rd_we and illegal are single-cycle pulses in DONE.
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign csr_we    = (state == S_WRITE);
    assign illegal   = done && ill_q;
    assign rd_we     = done && (rd_q != 5'd0) && read_q && !ill_q;
    assign state_dbg = state;

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Initiator side of the CSR register-file port: executes one Zicsr instruction (CSRRW/CSRRS/CSRRC and the immediate forms) per request. Sequences the read, the read-modify-write computation and the write-back onto the register file's `csr_addr`/`data_in`/`write_en`/`csr_readbus` port, then returns the old CSR value for the integer register write-back. Sits between the core's execute stage and the CSR register file.

## Interface
- `RD_LAT`, default 1: CSR read latency in cycles. This is the number of clock edges from a read address being driven with `csr_we=0` until `csr_readbus` is valid. Legal values are 1 to 3.
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  reset; **asynchronous, active-high** (the port name is kept as-is).
- `start`  in  1  request strobe; sampled only in IDLE.
- `funct3`  in  3  operation code:
  - 001 RW, 010 RS, 011 RC
  - 101 RWI, 110 RSI, 111 RCI
  - 000 and 100 are invalid.
- `csr_num`  in  12  CSR number.
- `rs1_data`  in  32  source operand for the register forms.
- `rs1_zimm`  in  5  rs1 index for the register forms, or zimm for the immediate forms.
- `rd_idx`  in  5  destination index.
- `csr_readbus`  in  32  read data from the CSR file.
- `csr_addr`  out  32  byte address `{18'b0, csr_num, 2'b00}`; the register file shifts it right by 2.
- `csr_wdata`  out  32  write data to the CSR file `data_in`.
- `csr_we`  out  1  write strobe to the CSR file `write_en`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rd_data`  out  32  old CSR value.
- `rd_we`  out  1  integer write-back enable; pulses together with `done`.
- `illegal`  out  1  illegal-access flag; pulses together with `done`.

## Operation
- **Request latch.** On the `start` edge in IDLE, the unit registers `funct3`, `csr_num`, `rd_idx` and the operand.
  - `src` is `rs1_data` for the register forms.
  - `src` is `{27'b0, rs1_zimm}` for the immediate forms.
  - `start` outside IDLE is ignored.
- **States.** IDLE, READ, CAPTURE, WRITE, DONE.
- **Transitions.**
  - IDLE→READ: default path.
  - IDLE→WRITE: RW/RWI with `rd_idx==0` (no read is performed).
  - IDLE→DONE: invalid `funct3`, or illegal access (see Configuration).
  - READ: held for `RD_LAT` cycles, with a down-counter; → CAPTURE.
  - CAPTURE: latches `old = csr_readbus`.
    - →DONE if RS/RC/RSI/RCI with `rs1_zimm==0` (no write).
    - →WRITE otherwise.
  - WRITE: one cycle; →DONE.
  - DONE: one cycle; →IDLE.
- **Write data**, registered on entry to WRITE:
  - RW/RWI: `src`
  - RS/RSI: `old | src`
  - RC/RCI: `old & ~src`
  - All values are 32-bit with no carry.
- **Return value.**
  - `rd_data` takes `old` in CAPTURE and holds until the next CAPTURE.
  - `rd_we = (rd_idx!=0) && read_performed && !illegal` in DONE.
- **Bus signals.**
  - `csr_addr` is registered on acceptance and held until the next acceptance.
  - `csr_we` is high only in WRITE.
  - `csr_wdata` holds its last value.
- **Invalid `funct3`.** No bus activity; DONE with `rd_we=0`.

## Timing
- **Reset.** Asynchronous, clears all of the following immediately, including mid-operation:
  - state → IDLE
  - `busy`, `done`, `rd_we`, `illegal`, `csr_we` = 0
  - `csr_addr`, `csr_wdata`, `rd_data` = 0
  - A WRITE interrupted by reset drops `csr_we` with no retry.
- **Latency**, counted from the edge that samples `start` to `done` high (RD_LAT=1):
  - Full read-modify-write: 4 cycles.
  - Write-only: 2 cycles.
  - Read-only: 3 cycles.
  - Invalid or illegal request: 1 cycle.
  - Each extra `RD_LAT` cycle adds 1 to the paths that read.
- **Read/write ordering.** `csr_we` is 0 throughout READ and CAPTURE, so the responder performs reads. The write is therefore never in the same cycle as the read.
- **Back-to-back requests.** `start` is accepted in the cycle after DONE, so the minimum request spacing equals the latency plus 1.
- **`busy`** is high from the cycle after acceptance through DONE inclusive.

## Configuration
- **`CSR_ACCESS_CHECK_EN` defined:**
  - `illegal` is asserted in DONE for an invalid `funct3`.
  - `illegal` is also asserted for any request that would write a CSR with `csr_num[11:10]==2'b11` (read-only space).
  - An illegal request performs no read and no write; `rd_we` is 0.
- **`CSR_ACCESS_CHECK_EN` undefined:**
  - `illegal` is tied to 0.
  - Writes to read-only numbers are issued normally; the responder discards them.
  - Invalid `funct3` still completes in DONE with no bus activity.

## Test plan
- **RW full path.** After reset, CSR 0x340 holds 0x1234_5678. Send `start` with RW, `rs1_data`=0xDEAD_BEEF, `rd_idx`=5.
  - One `csr_we` pulse with `csr_addr`=0x0000_0D00 and `csr_wdata`=0xDEAD_BEEF.
  - `done` is high 4 cycles after `start`, with `rd_data`=0x1234_5678 and `rd_we`=1.
- **RS/RC arithmetic.** mstatus (0x300) = 0x0000_0088.
  - RSI with zimm=0x01 writes 0x0000_0089.
  - RC with `rs1_data`=0x0000_0008 then writes 0x0000_0081.
- **No-write and no-read skips.**
  - RS with `rs1_zimm`=0: `csr_we` never asserted, `done` at 3 cycles, `rd_data` correct.
  - RW with `rd_idx`=0: no READ state, `done` at 2 cycles, `rd_we`=0.
- **Reset mid-WRITE.** Assert `resetn` during WRITE.
  - `csr_we` falls in the same cycle.
  - All outputs are 0 and the state is IDLE.
  - A new request afterwards completes normally.
- **Checking enabled.** With `CSR_ACCESS_CHECK_EN` defined, send RW to 0xF11.
  - `done` at 1 cycle with `illegal`=1, no `csr_we`, `rd_we`=0.
  - `funct3`=100 also gives `illegal`=1.
  - RS with zero operand to 0xF11 reads legally (`illegal`=0).
- **Ignored start and RD_LAT=2.** With `RD_LAT`=2, pulse `start` again while `busy`.
  - The second pulse is ignored.
  - The first request completes with `done` at 5 cycles.
  - The next `start` is accepted the cycle after DONE.
